// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit: funct3 codes, FSM states and
// request decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, XFER, RESP} lsu_state_e;

  // Number of byte accesses implied by the size field; the unused encoding is never legal.
  function automatic logic [2:0] byte_count(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   byte_count = 3'd1;
      2'b01:   byte_count = 3'd2;
      2'b10:   byte_count = 3'd4;
      default: byte_count = 3'd1;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] funct3, input logic we);
    if (we) begin
      is_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      is_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
    end
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   is_misaligned = addr_lo[0];
      2'b10:   is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of assembled little-endian load data according to funct3.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{24{data_i[7]}}, data_i[7:0]};
      F3_H:    data_o = {{16{data_i[15]}}, data_i[15:0]};
      F3_W:    data_o = data_i;
      F3_BU:   data_o = {24'h0, data_i[7:0]};
      F3_HU:   data_o = {16'h0, data_i[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_byte_serial.sv
// Byte-serial load/store initiator: one request becomes 1/2/4 byte accesses, then one response.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned halfword/word accesses as errors.
module lsu_byte_serial
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic              req_legal;
  logic [31:0]       ext_data;

  always_comb begin
    req_legal = is_legal(req_funct3, req_we);
`ifdef LSU_MISALIGN_CHECK_EN
    req_legal = req_legal && !is_misaligned(req_funct3, req_addr[1:0]);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          data_d   = '0;
          cnt_d    = '0;
          err_d    = !req_legal;
          state_d  = req_legal ? XFER : RESP;
        end
      end
      XFER: begin
        if (!we_q) begin
          data_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
        end
        cnt_d = cnt_q + 2'd1;
        if ({1'b0, cnt_q} == byte_count(funct3_q) - 3'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  lsu_load_extend u_load_extend (
    .funct3_i (funct3_q),
    .data_i   (data_q),
    .data_o   (ext_data)
  );

  // Memory and response outputs depend on registered state only.
  always_comb begin
    req_ready  = (state_q == IDLE) && !rst;
    mem_en     = (state_q == XFER);
    mem_we     = (state_q == XFER) && we_q;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q == XFER) begin
      mem_addr  = addr_q + {{(ADDR_W-2){1'b0}}, cnt_q};
      mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
    end
    resp_valid = (state_q == RESP);
    resp_err   = (state_q == RESP) && err_q;
    resp_rdata = ((state_q == RESP) && !err_q && !we_q) ? ext_data : '0;
  end

endmodule

// File: tb/tb_lsu_byte_serial.sv
// Bench for lsu_byte_serial: directed vector table, reset-abort sequence and random requests
// checked against a byte-array reference model.
module tb_lsu_byte_serial;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  lsu_byte_serial #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Responder memory
  logic [7:0] mem [256];
  logic       mem_clr;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  logic [7:0] ref_mem [256];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference behaviour from the request rules, on a flat byte array.
  task automatic model(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                       input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                       output int n);
    bit legal;
    longint v;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
`ifdef LSU_MISALIGN_CHECK_EN
    if ((n == 2 && addr % 2 != 0) || (n == 4 && addr % 4 != 0)) legal = 0;
`endif
    rdata = 0;
    if (!legal) begin
      err = 1'b1;
      n = 0;
      return;
    end
    err = 1'b0;
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[(int'(addr) + i) % 256] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + longint'(ref_mem[(int'(addr) + i) % 256]) * (64'd1 << (8*i));
      case (f3)
        3'd0: begin if (v > 127) v = v - 256; end
        3'd1: begin if (v > 32767) v = v - 65536; end
        default: ;
      endcase
      rdata = v[31:0];
    end
  endtask

  task automatic do_txn(input string name, input logic we, input logic [2:0] f3,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        input bit use_tbl, input logic tbl_err, input logic [31:0] tbl_rdata);
    logic m_err, g_err, exp_err;
    logic [31:0] m_rdata, g_rdata, exp_rdata;
    int n, nacc, lat;
    bit got, trace_ok;
    model(we, f3, addr, wdata, m_err, m_rdata, n);
    exp_err   = use_tbl ? tbl_err : m_err;
    exp_rdata = use_tbl ? tbl_rdata : m_rdata;
    @(negedge clk);
    check({name, " ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    // Keep valid high with garbage fields: they must be ignored after acceptance.
    req_we = ~we; req_funct3 = 3'($urandom); req_addr = 8'($urandom); req_wdata = $urandom;
    got = 0; trace_ok = 1; nacc = 0; lat = 0; g_err = 0; g_rdata = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (mem_en) begin
        if (nacc > 3) trace_ok = 0;
        else if (mem_addr != 8'((int'(addr) + nacc) % 256) || mem_we != we ||
                 (we && mem_wdata != wdata[8*nacc +: 8])) trace_ok = 0;
        nacc++;
      end
      if (req_ready) trace_ok = 0;
      if (resp_valid) begin
        got = 1; lat = c; g_err = resp_err; g_rdata = resp_rdata; req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check({name, " resp_seen"}, {31'd0, got}, 32'd1);
    check({name, " err"}, {31'd0, g_err}, {31'd0, exp_err});
    check({name, " rdata"}, g_rdata, exp_rdata);
    check({name, " latency"}, lat, m_err ? 1 : n + 1);
    check({name, " accesses"}, nacc, n);
    check({name, " trace"}, {31'd0, trace_ok}, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int mism, seen;
    rst = 1'b1; mem_clr = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    tbl.push_back('{1'b1, 3'd2, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 3'd0, 8'h10, 32'h0, 1'b0, 32'hFFFFFFEF});
    tbl.push_back('{1'b0, 3'd4, 8'h10, 32'h0, 1'b0, 32'h000000EF});
    tbl.push_back('{1'b0, 3'd1, 8'h12, 32'h0, 1'b0, 32'hFFFFDEAD});
    tbl.push_back('{1'b0, 3'd5, 8'h12, 32'h0, 1'b0, 32'h0000DEAD});
    tbl.push_back('{1'b0, 3'd2, 8'h10, 32'h0, 1'b0, 32'hDEADBEEF});
`ifdef LSU_MISALIGN_CHECK_EN
    tbl.push_back('{1'b1, 3'd2, 8'hFE, 32'h11223344, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 3'd2, 8'hFE, 32'h0, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 3'd1, 8'h03, 32'h0, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 3'd2, 8'h02, 32'h0, 1'b1, 32'h0});
`else
    tbl.push_back('{1'b1, 3'd2, 8'hFE, 32'h11223344, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 3'd2, 8'hFE, 32'h0, 1'b0, 32'h11223344});
    tbl.push_back('{1'b0, 3'd0, 8'h00, 32'h0, 1'b0, 32'h00000022});
    tbl.push_back('{1'b0, 3'd1, 8'h03, 32'h0, 1'b0, 32'h0});
`endif
    tbl.push_back('{1'b0, 3'd2, 8'h04, 32'h0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 3'd3, 8'h10, 32'h0, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 3'd4, 8'h10, 32'hCAFEF00D, 1'b1, 32'h0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", {31'd0, req_ready}, 32'd0);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst resp_err", {31'd0, resp_err}, 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst mem_en", {31'd0, mem_en}, 32'd0);
    check("rst mem_we", {31'd0, mem_we}, 32'd0);
    check("rst mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst mem_wdata", {24'd0, mem_wdata}, 32'd0);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    check("idle req_ready", {31'd0, req_ready}, 32'd1);
    check("idle mem_en", {31'd0, mem_en}, 32'd0);

    foreach (tbl[i]) begin
      do_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
             1'b1, tbl[i].err, tbl[i].rdata);
    end
    check("mem 0x10", {24'd0, mem[8'h10]}, 32'hEF);
    check("mem 0x13", {24'd0, mem[8'h13]}, 32'hDE);

    // Reset arrives while the second byte of a word store is on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 8'h20;
    req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort byte0 addr", {24'd0, mem_addr}, 32'h20);
    @(negedge clk);
    check("abort byte1 addr", {24'd0, mem_addr}, 32'h21);
    rst = 1'b1;
    @(negedge clk);
    check("abort mem_en", {31'd0, mem_en}, 32'd0);
    check("abort resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort ready in rst", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    seen = 0;
    @(negedge clk);
    check("abort ready after", {31'd0, req_ready}, 32'd1);
    repeat (6) begin
      if (mem_en || resp_valid) seen++;
      @(negedge clk);
    end
    check("abort quiet", seen, 0);
    check("abort mem 0x20", {24'd0, mem[8'h20]}, 32'hD4);
    check("abort mem 0x21", {24'd0, mem[8'h21]}, 32'hC3);
    check("abort mem 0x22", {24'd0, mem[8'h22]}, 32'h00);
    check("abort mem 0x23", {24'd0, mem[8'h23]}, 32'h00);
    ref_mem[8'h20] = 8'hD4;
    ref_mem[8'h21] = 8'hC3;

    for (int k = 0; k < 150; k++) begin
      do_txn($sformatf("rnd%0d", k), 1'($urandom), 3'($urandom_range(0, 7)),
             8'($urandom), $urandom, 1'b0, 1'b0, 32'h0);
    end

    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("final memory image", mism, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_byte_serial.md
Name: lsu_byte_serial

Overview:
- Load/store initiator between the core's memory stage and the byte-wide data memory.
- Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request, sequences it as 1, 2 or 4 single-byte memory accesses (little-endian), then returns one response.
- Read data is sign- or zero-extended to 32 bits.
- The memory is the responder: combinational byte read, byte write committed on the clock edge.

Parameters:
- ADDR_W, 8, byte-address width; byte addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  ADDR_W  base byte address
- req_wdata  in  32  store data; bytes [7:0] first
- resp_valid  out  1  one-cycle response pulse; no backpressure
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; illegal funct3 (or misaligned, see option)
- mem_en  out  1  memory byte access this cycle
- mem_we  out  1  byte write this cycle (qualified by mem_en)
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  byte to write
- mem_rdata  in  8  combinational read byte for mem_addr

Behaviour:
- Reset values: req_ready=0 while rst is high, then 1 in IDLE. resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. State is IDLE, byte counter is 0.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid&&req_ready, latch we, funct3, addr and wdata.
  - N = 1 for funct3[1:0]=00, 2 for 01, 4 for 10.
  - Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
  - Legal request goes to XFER with cnt=0. Illegal request goes straight to RESP with err=1 and no memory access.
- XFER:
  - mem_en=1, mem_we=we, mem_addr=base+cnt (wraps mod 2^ADDR_W), mem_wdata=wdata[8*cnt+7:8*cnt].
  - Loads capture mem_rdata into byte lane cnt on the edge.
  - cnt increments each edge. After the edge with cnt=N-1, go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle. Then IDLE.
  - Load data: LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes through.
  - Store: resp_rdata=0.
- Latency: with acceptance on edge E0, byte i is driven in the cycle after E_i. resp_valid is high in the cycle after E_N. The next request can be accepted at E_{N+2}. Error responses have resp_valid in the cycle after E0.
- mem_en=0 in IDLE and RESP. req_ready=0 in XFER and RESP; req_valid is ignored there.
- Reset mid-operation: next state is IDLE, mem_en drops in the cycle after the reset edge and no further bytes are issued. Already-committed bytes remain written. No response is produced.
- Outputs are registered or decoded from state only. There is no combinational path from req_* to mem_*.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=00, is an error. It takes the illegal-funct3 path: no memory access, resp_err=1.
- Undefined: misaligned accesses proceed byte-serially with address wrap.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum IDLE/XFER/RESP.
  - Function returning byte count from funct3.
  - Legality function taking funct3 and we.
- Sub-module lsu_load_extend: combinational; takes funct3 and the 32-bit assembled bytes; outputs the extended 32-bit result.

Test Plan:
- SW funct3=010, addr 0x10, wdata 0xDEADBEEF -> four write cycles: 0x10=EF, 0x11=BE, 0x12=AD, 0x13=DE. resp_valid in the cycle after E4, err=0, rdata=0.
- After that store: LB 0x10 -> 0xFFFFFFEF. LBU 0x10 -> 0x000000EF. LH 0x12 -> 0xFFFFDEAD. LHU 0x12 -> 0x0000DEAD. LW 0x10 -> 0xDEADBEEF.
- SW 0xFE, data 0x11223344, macro undefined -> bytes written to 0xFE, 0xFF, 0x00, 0x01. LW 0xFE returns 0x11223344.
- Load funct3=011 or store funct3=100 -> resp_valid in the cycle after acceptance, err=1, rdata=0, mem_en never asserted.
- rst asserted after 2 bytes of SW to 0x20 -> mem_en=0 from the next cycle, no resp_valid. Only 0x20 and 0x21 are written. req_ready=1 once rst is released.
- With LSU_MISALIGN_CHECK_EN, LH 0x03 and LW 0x02 -> err=1, no memory access. LW 0x04 proceeds normally.
